// File: rtl/ica_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ica_pkg
//  Description : Shared sizes, sample/window/frame types and the saturating
//                narrowing helper used by the ICA window buffer.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Contents
//    N, CH, DW      window length, channel count, sample width
//    LOGN, ACCW     log2(N) and accumulator width (DW + log2 N)
//    sample_t       one signed sample
//    window_t       N samples of one channel
//    frame_t        CH windows, i.e. one complete multichannel window
//    sat_dw()       clamp a DW+1-bit signed value into the DW-bit range
// ============================================================================
package ica_pkg;

    localparam int N    = 64;
    localparam int CH   = 3;
    localparam int DW   = 32;
    localparam int LOGN = $clog2(N);
    localparam int ACCW = DW + LOGN;

    typedef logic signed [DW-1:0] sample_t;
    typedef sample_t [0:N-1]      window_t;
    typedef window_t [0:CH-1]     frame_t;

    localparam sample_t SAMPLE_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(DW-1){1'b0}}};

    // The difference of two DW-bit values needs DW+1 bits. If the two top
    // bits agree the value already fits in DW bits; otherwise the sign bit
    // tells which rail was crossed.
    function automatic sample_t sat_dw(input logic signed [DW:0] diff);
        sample_t res;
        if (diff[DW] == diff[DW-1]) begin
            res = diff[DW-1:0];
        end else if (diff[DW]) begin
            res = SAMPLE_MIN;
        end else begin
            res = SAMPLE_MAX;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ica_chan_acc.sv
`default_nettype none
// ============================================================================
//  Module      : ica_chan_acc
//  Description : Per-channel running sum of the window being filled, plus one
//                latched mean per buffer bank. The mean of a window is
//                captured on the accept that completes it and is held until
//                that bank is refilled.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         clock, rising edge
//    rst         asynchronous active-high reset
//    accept_i    a sample is accepted this cycle
//    last_i      the accepted sample is the last one of its window
//    wr_bank_i   bank currently being filled
//    rd_bank_i   bank currently presented to the consumer
//    data_i      this channel's sample
//    mean_o      latched mean of the bank selected by rd_bank_i
// ============================================================================
module ica_chan_acc
    import ica_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    accept_i,
    input  logic    last_i,
    input  logic    wr_bank_i,
    input  logic    rd_bank_i,
    input  sample_t data_i,
    output sample_t mean_o
);

    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] win_sum;
    sample_t                mean_q [2];
    sample_t                mean_d [2];

    always_comb begin
        // ACCW bits hold N full-scale samples, so the running sum cannot wrap.
        win_sum = acc_q + ACCW'(data_i);
        acc_d   = acc_q;
        mean_d  = mean_q;
        if (accept_i) begin
            if (last_i) begin
                acc_d             = '0;
                // Arithmetic shift: divide by N rounding toward -infinity.
                mean_d[wr_bank_i] = sample_t'(win_sum >>> LOGN);
            end else begin
                acc_d = win_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            mean_q[0] <= '0;
            mean_q[1] <= '0;
        end else begin
            acc_q     <= acc_d;
            mean_q[0] <= mean_d[0];
            mean_q[1] <= mean_d[1];
        end
    end

    assign mean_o = mean_q[rd_bank_i];

endmodule
`default_nettype wire

// File: rtl/ica_window_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ica_window_buffer
//  Description : Collects a stream of CH-channel signed samples into N-sample
//                windows using two ping-pong banks, optionally removes the
//                per-channel window mean, and presents each finished window
//                as a parallel array with a valid/ack handshake. One bank
//                fills while the other is being consumed.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CENTER       1 = present samples minus the window mean (saturated),
//                 0 = present raw samples and a zero mean
//  Ports
//    clk          clock, rising edge
//    rst          asynchronous active-high reset
//    s_valid      input sample valid
//    s_ready      a sample can be accepted this cycle (registers only)
//    s_data       one sample per channel
//    frame_valid  u holds a complete window
//    frame_ack    consumer has taken the presented window
//    u            presented window [channel][index], zero when not valid
//    frame_mean   per-channel mean of the presented window
//    frame_cnt    windows completed since reset, modulo 2^16
// ============================================================================
module ica_window_buffer
    import ica_pkg::*;
#(
    parameter int CENTER = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  sample_t [0:CH-1] s_data,
    output logic             frame_valid,
    input  logic             frame_ack,
    output frame_t           u,
    output sample_t [0:CH-1] frame_mean,
    output logic [15:0]      frame_cnt
);

    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    frame_t           bank_q [2];       // sample storage, intentionally unreset
    logic [1:0]       bank_full_q;
    logic [1:0]       bank_full_d;
    logic             wr_bank_q;
    logic             wr_bank_d;
    logic             rd_bank_q;
    logic             rd_bank_d;
    logic [LOGN-1:0]  wr_idx_q;
    logic [LOGN-1:0]  wr_idx_d;
    logic [15:0]      frame_cnt_q;
    logic [15:0]      frame_cnt_d;

    logic             accept;
    logic             win_done;
    logic             take;
    sample_t [0:CH-1] rd_mean;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // s_ready depends on registers only, so a same-cycle ack never reaches
    // it combinationally; a freed write bank shows up one cycle later.
    assign s_ready     = ~bank_full_q[wr_bank_q];
    assign frame_valid = bank_full_q[rd_bank_q];
    assign accept      = s_valid & s_ready;
    assign win_done    = accept & (wr_idx_q == LAST_IDX);
    assign take        = frame_valid & frame_ack;
    assign frame_cnt   = frame_cnt_q;

    // ------------------------------------------------------------------
    // Control next state
    // ------------------------------------------------------------------
    // A completion targets an empty bank and an ack targets a full one, so
    // the two updates of bank_full_d can never hit the same bit.
    always_comb begin
        bank_full_d = bank_full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_idx_d    = wr_idx_q;
        frame_cnt_d = frame_cnt_q;

        if (accept) begin
            wr_idx_d = wr_idx_q + LOGN'(1);
        end
        if (win_done) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
            wr_idx_d               = '0;
            frame_cnt_d            = frame_cnt_q + 16'd1;
        end
        if (take) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Bank write port. Contents are meaningless until a window completes,
    // so no reset is needed here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < CH; c++) begin
                bank_q[wr_bank_q][c][wr_idx_q] <= s_data[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel accumulators and mean latches
    // ------------------------------------------------------------------
    for (genvar c = 0; c < CH; c++) begin : g_chan
        ica_chan_acc u_acc (
            .clk       (clk),
            .rst       (rst),
            .accept_i  (accept),
            .last_i    (win_done),
            .wr_bank_i (wr_bank_q),
            .rd_bank_i (rd_bank_q),
            .data_i    (s_data[c]),
            .mean_o    (rd_mean[c])
        );
    end

    // ------------------------------------------------------------------
    // Output view. The read bank and its mean are frozen while it is
    // full, so u is stable for the whole time frame_valid is high.
    // ------------------------------------------------------------------
    always_comb begin
        u          = '0;
        frame_mean = '0;
        if (frame_valid) begin
            for (int c = 0; c < CH; c++) begin
                if (CENTER != 0) begin
                    frame_mean[c] = rd_mean[c];
                end
                for (int k = 0; k < N; k++) begin
                    if (CENTER != 0) begin
                        u[c][k] = sat_dw((DW+1)'($signed(bank_q[rd_bank_q][c][k]))
                                       - (DW+1)'($signed(rd_mean[c])));
                    end else begin
                        u[c][k] = bank_q[rd_bank_q][c][k];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ica_window_buffer.md
Name: ica_window_buffer

Overview:
Upstream feeder for the u·uᵀ dot-product array. It accepts a stream of 3-channel signed samples and assembles them into 64-sample windows in a ping-pong (two-bank) buffer. Each completed window is optionally mean-centred per channel. It is then presented as the parallel array u[0:2][0:63] with a valid/ack handshake. Filling of the next window continues while the previous one is being consumed.

Parameters:
N, 64, samples per window (power of two, ≥ 2)
CH, 3, channels per sample
DW, 32, sample width in bits (signed two's complement)
CENTER, 1, 1 = subtract the per-channel window mean on output; 0 = pass raw samples

Ports:
clk  input  1  clock, all state on its rising edge
rst  input  1  reset, asynchronous, active-high
s_valid  input  1  input sample valid
s_ready  output  1  buffer can accept a sample this cycle
s_data  input  CH×DW signed, [0:CH-1]  one sample per channel
frame_valid  output  1  u holds a complete window
frame_ack  input  1  consumer has taken the window
u  output  CH×N×DW signed, [0:CH-1][0:N-1]  window data, centred if CENTER=1
frame_mean  output  CH×DW signed  per-channel mean of the presented window
frame_cnt  output  16  windows completed since reset, wraps modulo 2^16

Behaviour:
- Storage:
  - Two banks, each CH×N×DW. The bank arrays are not reset.
  - bank_full[1:0], wr_bank, rd_bank and wr_idx (log2 N bits) are reset.
  - Reset values: all zero. s_ready=1 and frame_valid=0 from reset assertion.
- Write side:
  - s_ready = !bank_full[wr_bank], combinational from registers only.
  - A sample is accepted when s_valid && s_ready. It is written to bank[wr_bank][ch][wr_idx], wr_idx increments, and s_data is added to acc[ch].
  - acc is signed, DW+log2 N bits, cleared at window start.
- Window completion (accept at wr_idx=N-1):
  - bank_full[wr_bank] is set and wr_bank toggles. wr_idx and acc clear.
  - mean[wr_bank][ch] is latched as (acc + s_data) >>> log2 N: arithmetic shift, floor toward −∞.
- Read side:
  - frame_valid = bank_full[rd_bank].
  - On frame_valid && frame_ack: bank_full[rd_bank] clears and rd_bank toggles.
  - frame_ack while frame_valid=0 is ignored.
- Latency: frame_valid rises on the cycle after the N-th sample of a window is accepted. The minimum is N accepted cycles from the first sample.
- Output data:
  - While frame_valid=1: u[ch][k] = sat_DW(bank[rd_bank][ch][k] − mean[rd_bank][ch]) when CENTER=1, else the raw bank value.
  - frame_mean = mean[rd_bank] (0 when CENTER=0).
  - sat_DW clamps the DW+1-bit difference to [−2^(DW−1), 2^(DW−1)−1].
  - While frame_valid=0: u and frame_mean are driven to 0.
  - u is stable for the whole time frame_valid is high.
- Simultaneous events:
  - Window completion on one bank and ack on the other in the same cycle: both take effect.
  - When both banks are full, s_ready=0. An ack in that cycle frees rd_bank. If that bank equals wr_bank, s_ready rises the next cycle; no combinational ready-from-ack path.
  - Completion and ack can never target the same bank in one cycle.
- Backpressure: samples are never dropped. s_data is sampled only on accept.
- frame_cnt increments on each window completion.
- Reset mid-window discards partial and full windows. After reset the first accepted sample goes to bank 0, index 0.

Decomposition:
- Package ica_pkg:
  - localparams N, CH, DW and ACCW = DW+$clog2(N)
  - typedef sample_t (signed DW), window_t (sample_t [0:N-1]), frame_t (window_t [0:CH-1])
  - function sat_dw
- One sub-module, ica_chan_acc: a per-channel accumulator plus mean latch, instantiated CH times.
- Bank storage and control stay in the top.

Test Plan:
- Reset then 64 samples with ch0=k, ch1=−k, ch2=100 and CENTER=1 → frame_valid on cycle 65. frame_mean={31,−32,100}. u[0][0]=−31, u[1][63]=−31, u[2][*]=0. frame_cnt=1.
- 128 samples back-to-back with no ack → frame_valid after 64, s_ready falls after the 128th accept. A 129th offered sample is held. Ack → first window replaced by the second on the next cycle, s_ready=1 the cycle after.
- Ack on the same cycle the other bank completes → frame_valid stays 1, u switches to the new window, frame_cnt increments, no lost window.
- ch0 samples alternate 0x7FFFFFFF and 0x80000000 → mean=−1 (floor). u[0] shows 0x7FFFFFFF (saturated) and 0x80000001.
- Random s_valid gaps and random ack delays over 1000 windows → scoreboard matches every window in order, with no drop or duplicate.
- Assert rst asynchronously mid-window (no clock edge) → frame_valid=0, u=0 and s_ready=1 immediately. The next 64 samples form a clean window.
